imem_prefetch: RTL and testbench
================================

# imem_prefetch

Instruction prefetch unit between the core's instruction port and an external instruction memory with a valid/ready request channel and variable-latency, in-order responses. It issues sequential word fetches ahead of the core and buffers returned instructions in a DEPTH-entry FIFO. It presents them to the core as a valid/ready stream tagged with their PC, and flushes cleanly on a core redirect (branch/jump).

## Interface
- DEPTH, 4: FIFO entries and maximum requests in flight; power of 2, ≥2.
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.

Reset: one clock; reset is asynchronous and active-high.
- sysclk  in  1  system clock, rising edge.
- rst_in  in  1  asynchronous reset.
- mem_req_valid  out  1  fetch request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  32  word-aligned fetch address.
- mem_rsp_valid  in  1  response data valid; responses return in request order; no backpressure.
- mem_rsp_data  in  32  instruction word.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  core consumes head.
- instr_data  out  32  head instruction.
- instr_pc  out  32  address the head instruction was fetched from.
- redirect_in  in  1  flush and restart fetch, one-cycle pulse.
- redirect_pc_in  in  32  new fetch address; bits [1:0] are ignored and forced to 0.

## Operation
- State:
  - fetch_pc register, driving mem_req_addr.
  - FIFO of {pc, data}, DEPTH entries, with count 0..DEPTH.
  - outstanding counter 0..DEPTH, counting accepted requests not yet responded.
  - discard counter 0..DEPTH, counting stale in-flight responses to drop.
- live = outstanding − discard.
- Issue: mem_req_valid = !redirect_in && outstanding < DEPTH && count + live < DEPTH.
- Request handshake (valid && ready): fetch_pc += 4, wrapping modulo 2^32; outstanding += 1.
- Address stability: mem_req_addr stays stable while mem_req_valid && !mem_req_ready, except on redirect.
- Response with discard > 0: data dropped; discard −= 1; outstanding −= 1.
- Response with discard = 0: {pc, data} is pushed to the FIFO; outstanding −= 1.
  - The PC for each entry comes from a response-PC register that tracks issue order. It is set on redirect and advanced by 4 per accepted response.
- Pop: instr_valid && instr_ready removes the head.
- Push and pop in the same cycle: count unchanged.
- The credit rule guarantees a push never finds the FIFO full. A push arriving with count = DEPTH is a design error; flag it with a simulation assertion.
- Redirect cycle, all of these take effect:
  - FIFO flushed: count ← 0, and any same-cycle pop is ignored.
  - fetch_pc ← {redirect_pc_in[31:2], 2'b00}.
  - The response-PC register is set to the same value.
  - discard ← outstanding − (mem_rsp_valid ? 1 : 0).
  - A response arriving in the redirect cycle is dropped and decrements outstanding.
  - mem_req_valid forced 0.
- Back-to-back redirects: each one reloads the addresses and recomputes discard from the current outstanding count.

## Timing
- Reset values:
  - mem_req_valid=0, mem_req_addr=RESET_PC.
  - instr_valid=0, instr_data=0, instr_pc=0.
  - count=0, outstanding=0, discard=0.
- First cycle after reset release: mem_req_valid=1 with RESET_PC.
- Reset asserted mid-operation: state is cleared immediately. Responses still in flight after release are not tracked; the memory must also be reset.
- Latency:
  - Response accepted at edge N → instr_valid=1 after edge N (FIFO registered, no bypass).
  - Redirect sampled at edge N → new request visible after edge N.
  - instr_valid=0 after edge N.
- Throughput: with zero-wait memory and instr_ready held at 1, one instruction per cycle sustained.
- Outputs instr_* are driven from FIFO registers with no combinational path from mem_rsp_*. mem_req_valid depends combinationally only on redirect_in and state.

## Test plan
- Reset release with memory ready=1, response one cycle after acceptance, core ready=1:
  - Addresses 0x0, 0x4, 0x8… issued on consecutive cycles.
  - instr_pc/instr_data stream matches in order.
  - One instruction per cycle after fill.
- Core stall: instr_ready=0 with DEPTH=4:
  - Exactly 4 requests issued, then mem_req_valid=0 while count=4.
  - Releasing ready for 1 cycle allows exactly one new request.
- Memory backpressure: mem_req_ready=0 for 5 cycles:
  - mem_req_valid stays 1 and mem_req_addr stays at 0x8 throughout.
  - Then 0x8 is accepted and 0xC follows.
- Redirect with 3 outstanding, redirect_pc_in=0x1002:
  - Next request address is 0x1000.
  - The 3 stale responses are dropped.
  - The first delivered instruction has instr_pc=0x1000.
- Corner cases:
  - Redirect coinciding with a response and a pop: response dropped, discard=outstanding−1, FIFO empty next cycle.
  - Back-to-back redirects to 0x200 then 0x300: only 0x300-stream instructions delivered.
  - fetch_pc near 0xFFFF_FFFC wraps to 0x0.

Source files
------------

// File: rtl/imem_prefetch.sv
// Sequential instruction prefetcher: issues word fetches ahead of the core and buffers them in a DEPTH-entry FIFO.
// Response-to-instr_valid latency is one cycle (registered FIFO). Requests stall when in-flight plus buffered words would overflow the FIFO.
module imem_prefetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push_vld,
  input  logic [W-1:0]  push_dat,
  input  logic          pop_rdy,
  output logic          pop_vld,
  output logic [W-1:0]  pop_dat,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          pop;

  assign pop_vld = (count != '0);
  assign pop_dat = mem[rd_ptr];
  assign pop     = pop_rdy && pop_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_vld) - CW'(pop);
    end
  end
endmodule

module imem_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        sysclk,
  input  logic        rst_in,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] dat;
  } ent_t;

  logic [31:0] fetch_pc;
  logic [31:0] rsp_pc;
  logic [31:0] new_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] live;
  logic [CW-1:0] fifo_cnt;
  logic [CW:0]   committed;
  logic          req_fire;
  logic          fifo_push;
  ent_t          push_ent;
  ent_t          head_ent;

  assign new_pc    = redirect_pc_in & 32'hFFFF_FFFC;
  assign live      = outstanding - discard;
  // Live requests already own a FIFO slot, so the FIFO can never overflow.
  assign committed = {1'b0, fifo_cnt} + {1'b0, live};

  assign mem_req_valid = !rst_in && !redirect_in
                      && (outstanding < CW'(DEPTH))
                      && (committed < (CW+1)'(DEPTH));
  assign mem_req_addr  = fetch_pc;
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign fifo_push     = mem_rsp_valid && !redirect_in && (discard == '0);

  assign push_ent.pc  = rsp_pc;
  assign push_ent.dat = mem_rsp_data;

  always_ff @(posedge sysclk or posedge rst_in) begin
    if (rst_in) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(mem_rsp_valid);
      if (redirect_in) begin
        fetch_pc <= new_pc;
        rsp_pc   <= new_pc;
        discard  <= outstanding - CW'(mem_rsp_valid);
      end else begin
        if (req_fire)  fetch_pc <= fetch_pc + 32'd4;
        if (fifo_push) rsp_pc   <= rsp_pc + 32'd4;
        if (mem_rsp_valid && (discard != '0)) discard <= discard - 1'b1;
      end
    end
  end

  imem_prefetch_fifo #(.W($bits(ent_t)), .DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk      (sysclk),
    .rst      (rst_in),
    .flush    (redirect_in),
    .push_vld (fifo_push),
    .push_dat (push_ent),
    .pop_rdy  (instr_ready),
    .pop_vld  (instr_valid),
    .pop_dat  (head_ent),
    .count    (fifo_cnt)
  );

  assign instr_pc   = head_ent.pc;
  assign instr_data = head_ent.dat;

  a_no_push_when_full: assert property (@(posedge sysclk) disable iff (rst_in)
    !(fifo_push && (fifo_cnt == CW'(DEPTH))));
endmodule

// File: tb/tb_imem_prefetch.sv
// Bench for imem_prefetch: in-order variable-latency memory model plus a PC-stream scoreboard,
// directed scenarios followed by a randomized phase with random stalls and redirects.
module tb_imem_prefetch;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        sysclk = 1'b0;
  logic        rst_in;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        redirect_in;
  logic [31:0] redirect_pc_in;

  imem_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .sysclk         (sysclk),
    .rst_in         (rst_in),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .redirect_in    (redirect_in),
    .redirect_pc_in (redirect_pc_in)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] popped[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          n_req = 0;
  int          n_pop = 0;
  int          n0;
  int          mem_rdy_pct = 100;
  int          core_rdy_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;
  logic        do_redirect = 1'b0;
  logic [31:0] redir_pc = 32'h0;
  logic [31:0] exp_req_pc = RESET_PC;
  logic [31:0] exp_pop_pc = RESET_PC;
  logic        prev_stall = 1'b0;
  logic        prev_redirect = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic        s_req_vld;
  logic        s_req_fire;
  logic        s_instr_vld;
  logic [31:0] s_req_addr;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive at the falling edge, sample 1ns later, advance to the next falling edge.
  task automatic step();
    logic  rsp_now;
    mreq_t r;
    redirect_in    = do_redirect;
    redirect_pc_in = redir_pc;
    do_redirect    = 1'b0;
    rsp_now        = (mq.size() != 0) && (mq[0].due <= cyc);
    mem_rsp_valid  = rsp_now;
    mem_rsp_data   = rsp_now ? mdata(mq[0].addr) : 32'h0;
    mem_req_ready  = ($urandom_range(99) < mem_rdy_pct);
    instr_ready    = ($urandom_range(99) < core_rdy_pct);
    #1;
    s_req_vld   = mem_req_valid;
    s_req_addr  = mem_req_addr;
    s_instr_vld = instr_valid;
    s_req_fire  = mem_req_valid && mem_req_ready;
    if (redirect_in) check("req_vld_in_redirect", {63'h0, mem_req_valid}, 64'h0);
    if (prev_redirect) check("instr_vld_after_redirect", {63'h0, instr_valid}, 64'h0);
    if (prev_stall && !redirect_in)
      check("req_stable", {31'h0, mem_req_valid, mem_req_addr}, {31'h0, 1'b1, prev_addr});
    if (s_req_fire) begin
      check("req_addr", {32'h0, mem_req_addr}, {32'h0, exp_req_pc});
      r.addr = mem_req_addr;
      r.due  = cyc + $urandom_range(lat_max, lat_min);
      mq.push_back(r);
      exp_req_pc += 32'd4;
      n_req++;
    end
    if (instr_valid && instr_ready && !redirect_in) begin
      check("instr_pc", {32'h0, instr_pc}, {32'h0, exp_pop_pc});
      check("instr_data", {32'h0, instr_data}, {32'h0, mdata(exp_pop_pc)});
      popped.push_back(instr_pc);
      exp_pop_pc += 32'd4;
      n_pop++;
    end
    if (rsp_now) void'(mq.pop_front());
    check("outstanding_bound", {63'h0, mq.size() <= DEPTH}, 64'h1);
    if (redirect_in) begin
      exp_req_pc = redirect_pc_in & 32'hFFFF_FFFC;
      exp_pop_pc = redirect_pc_in & 32'hFFFF_FFFC;
      popped.delete();
    end
    prev_stall    = mem_req_valid && !mem_req_ready;
    prev_addr     = mem_req_addr;
    prev_redirect = redirect_in;
    @(negedge sysclk);
    cyc++;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    do_redirect = 1'b1;
    redir_pc    = pc;
    step();
  endtask

  initial begin
    rst_in         = 1'b1;
    mem_req_ready  = 1'b0;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = 32'h0;
    instr_ready    = 1'b0;
    redirect_in    = 1'b0;
    redirect_pc_in = 32'h0;
    repeat (2) @(negedge sysclk);
    #1;
    check("rst_req_vld", {63'h0, mem_req_valid}, 64'h0);
    check("rst_req_addr", {32'h0, mem_req_addr}, {32'h0, RESET_PC});
    check("rst_instr_vld", {63'h0, instr_valid}, 64'h0);
    check("rst_instr_data", {32'h0, instr_data}, 64'h0);
    check("rst_instr_pc", {32'h0, instr_pc}, 64'h0);
    rst_in = 1'b0;

    // Zero-wait memory, always-ready core: full-rate stream from RESET_PC.
    step();
    check("first_req", {31'h0, s_req_vld, s_req_addr}, {31'h0, 1'b1, RESET_PC});
    repeat (3) step();
    n0 = n_pop;
    begin
      int r0;
      r0 = n_req;
      repeat (20) step();
      check("stream_pops", 64'(n_pop - n0), 64'd20);
      check("stream_reqs", 64'(n_req - r0), 64'd20);
    end

    // Core stall: exactly DEPTH requests, then one more per freed slot.
    core_rdy_pct = 0;
    redirect_to(32'h0000_0100);
    n0 = n_req;
    repeat (10) step();
    check("stall_reqs", 64'(n_req - n0), 64'(DEPTH));
    check("stall_req_vld", {63'h0, s_req_vld}, 64'h0);
    core_rdy_pct = 100;
    step();
    core_rdy_pct = 0;
    n0 = n_req;
    repeat (6) step();
    check("one_slot_reqs", 64'(n_req - n0), 64'd1);
    check("one_slot_req_vld", {63'h0, s_req_vld}, 64'h0);

    // Memory backpressure holds address 0x8.
    core_rdy_pct = 100;
    redirect_to(32'h0);
    step();
    step();
    mem_rdy_pct = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold", {31'h0, s_req_vld, s_req_addr}, {31'h0, 1'b1, 32'h8});
    end
    mem_rdy_pct = 100;
    step();
    check("bp_accept8", {31'h0, s_req_fire, s_req_addr}, {31'h0, 1'b1, 32'h8});
    step();
    check("bp_then_c", {31'h0, s_req_fire, s_req_addr}, {31'h0, 1'b1, 32'hC});

    // Redirect with three requests in flight.
    lat_min = 6;
    lat_max = 6;
    redirect_to(32'h0000_2000);
    repeat (3) step();
    check("three_outstanding", 64'(mq.size()), 64'd3);
    redirect_to(32'h0000_1002);
    step();
    check("redir_addr", {31'h0, s_req_vld, s_req_addr}, {31'h0, 1'b1, 32'h1000});
    for (int i = 0; i < 40 && popped.size() == 0; i++) step();
    check("redir_first_pc", {32'h0, (popped.size() > 0) ? popped[0] : 32'hDEAD_BEEF}, 64'h1000);

    // Redirect colliding with a response and a pop.
    lat_min = 1;
    lat_max = 1;
    repeat (12) step();
    redirect_to(32'h0000_4000);
    check("collide_head_vld", {63'h0, s_instr_vld}, 64'h1);
    repeat (10) step();

    // Back-to-back redirects.
    lat_min = 1;
    lat_max = 4;
    mem_rdy_pct = 70;
    core_rdy_pct = 80;
    redirect_to(32'h0000_0200);
    redirect_to(32'h0000_0300);
    repeat (40) step();
    check("b2b_first_pc", {32'h0, (popped.size() > 0) ? popped[0] : 32'hDEAD_BEEF}, 64'h300);

    // Address wrap at the top of memory.
    lat_min = 1;
    lat_max = 1;
    mem_rdy_pct = 100;
    core_rdy_pct = 100;
    redirect_to(32'hFFFF_FFF4);
    repeat (12) step();
    check("wrap_pc3", {32'h0, (popped.size() > 4) ? popped[3] : 32'hDEAD_BEEF}, 64'h0);
    check("wrap_pc4", {32'h0, (popped.size() > 4) ? popped[4] : 32'hDEAD_BEEF}, 64'h4);

    // Randomized traffic with random latency, stalls and redirects.
    mem_rdy_pct = 60;
    core_rdy_pct = 70;
    lat_max = 5;
    n0 = n_pop;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 3) begin
        do_redirect = 1'b1;
        redir_pc    = $urandom;
      end
      step();
    end
    check("random_progress", {63'h0, (n_pop - n0) > 500}, 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
